// File: rtl/mc_cunit_pkg.sv
// mc_cunit_pkg: shared types and constants for the multi-cycle MIPS control unit.
//   - state_e   : FSM state encoding (4 bits)
//   - OP_*      : primary opcodes (instr[31:26]) understood by the unit
//   - AOP_*     : ALU operation codes driven on AOp
//   - ALUB_*    : ALU B-input select codes driven on ALUsrc
//   - ctrl_t    : packed bundle of every control strobe, produced by the decoder
package mc_cunit_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned AOP_MIN = 3;
  localparam int unsigned ALUB_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REX    = 4'd3,
    S_RWB    = 4'd4,
    S_IEX    = 4'd5,
    S_IWB    = 4'd6,
    S_MADR   = 4'd7,
    S_MRD    = 4'd8,
    S_MWR    = 4'd9,
    S_MWB    = 4'd10,
    S_BEQ    = 4'd11,
    S_JMP    = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [AOP_MIN-1:0] AOP_NONE  = 3'b000;
  localparam logic [AOP_MIN-1:0] AOP_SUB   = 3'b001;
  localparam logic [AOP_MIN-1:0] AOP_FUNCT = 3'b010;
  localparam logic [AOP_MIN-1:0] AOP_ADD   = 3'b011;
  localparam logic [AOP_MIN-1:0] AOP_SLT   = 3'b100;
  localparam logic [AOP_MIN-1:0] AOP_AND   = 3'b101;
  localparam logic [AOP_MIN-1:0] AOP_OR    = 3'b110;

  localparam logic [ALUB_W-1:0] ALUB_RT     = 2'b00;
  localparam logic [ALUB_W-1:0] ALUB_FOUR   = 2'b01;
  localparam logic [ALUB_W-1:0] ALUB_IMM    = 2'b10;
  localparam logic [ALUB_W-1:0] ALUB_IMMSH2 = 2'b11;

  // Complete set of control strobes for one cycle.
  typedef struct packed {
    logic                pc_write;
    logic                branch;
    logic                jump;
    logic                iord;
    logic                mread;
    logic                mwrite;
    logic                ir_write;
    logic                mtor;
    logic                regds;
    logic                urw;
    logic                alusrc_a;
    logic [ALUB_W-1:0]   alusrc;
    logic [AOP_MIN-1:0]  aop;
    logic                instr_done;
    logic                illegal;
  } ctrl_t;

  // True for every opcode the unit can sequence.
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
      OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for the immediate-ALU execute step.
  function automatic logic [AOP_MIN-1:0] iex_aop(input logic [OP_W-1:0] op);
    logic [AOP_MIN-1:0] a;
    a = AOP_ADD;
    case (op)
      OP_ADDI: a = AOP_ADD;
      OP_SLTI: a = AOP_SLT;
      OP_ANDI: a = AOP_AND;
      OP_ORI:  a = AOP_OR;
      default: a = AOP_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mc_cunit_odec.sv
// mc_cunit_odec: combinational output decoder for the multi-cycle control unit.
// Ports:
//   state    in   current FSM state (registered in the top level)
//   uin      in   live opcode; only looked at in S_DECODE (IR is stable there)
//   opcode   in   opcode captured at decode; drives the S_IEX ALU operation
//   mem_rdy  in   effective memory-ready (already forced high if handshake off)
//   ctrl_c   out  control strobes for this cycle
// Outputs depend on state only, except the mem_rdy gating of the fetch
// strobes and store completion, and the illegal-NOP completion in decode.
module mc_cunit_odec
  import mc_cunit_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  state_e          state,
  input  logic [OP_W-1:0] uin,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_rdy,
  output ctrl_t           ctrl_c
);

  // Per-state strobe decode; everything not set stays 0.
  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mread    = 1'b1;
        ctrl_c.iord     = 1'b0;
        ctrl_c.alusrc_a = 1'b0;
        ctrl_c.alusrc   = ALUB_FOUR;
        ctrl_c.aop      = AOP_ADD;
        // IR and PC only load once memory has returned the word.
        ctrl_c.ir_write = mem_rdy;
        ctrl_c.pc_write = mem_rdy;
      end
      S_DECODE: begin
        ctrl_c.alusrc_a   = 1'b0;
        ctrl_c.alusrc     = ALUB_IMMSH2;
        ctrl_c.aop        = AOP_ADD;
        // An unsupported opcode skipped as a NOP finishes right here.
        ctrl_c.instr_done = !ILLEGAL_TRAP && !op_supported(uin);
      end
      S_REX: begin
        ctrl_c.alusrc_a = 1'b1;
        ctrl_c.alusrc   = ALUB_RT;
        ctrl_c.aop      = AOP_FUNCT;
      end
      S_RWB: begin
        ctrl_c.regds      = 1'b1;
        ctrl_c.mtor       = 1'b0;
        ctrl_c.urw        = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_IEX: begin
        ctrl_c.alusrc_a = 1'b1;
        ctrl_c.alusrc   = ALUB_IMM;
        ctrl_c.aop      = iex_aop(opcode);
      end
      S_IWB: begin
        ctrl_c.regds      = 1'b0;
        ctrl_c.mtor       = 1'b0;
        ctrl_c.urw        = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_MADR: begin
        ctrl_c.alusrc_a = 1'b1;
        ctrl_c.alusrc   = ALUB_IMM;
        ctrl_c.aop      = AOP_ADD;
      end
      S_MRD: begin
        ctrl_c.mread = 1'b1;
        ctrl_c.iord  = 1'b1;
      end
      S_MWR: begin
        ctrl_c.mwrite     = 1'b1;
        ctrl_c.iord       = 1'b1;
        // A store is complete on the cycle memory accepts it.
        ctrl_c.instr_done = mem_rdy;
      end
      S_MWB: begin
        ctrl_c.regds      = 1'b0;
        ctrl_c.mtor       = 1'b1;
        ctrl_c.urw        = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl_c.alusrc_a   = 1'b1;
        ctrl_c.alusrc     = ALUB_RT;
        ctrl_c.aop        = AOP_SUB;
        ctrl_c.branch     = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_JMP: begin
        ctrl_c.jump       = 1'b1;
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_TRAP: begin
        ctrl_c.illegal = 1'b1;
      end
      default: begin
        ctrl_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_cunit.sv
// mc_cunit: multi-cycle MIPS control unit. Steps each instruction through
// fetch / decode / execute / memory / writeback on a shared datapath.
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   UIn            opcode instr[31:26], sampled in S_DECODE
//   mem_ready      memory finished the current access
//   PCWrite, Branch, Jump           PC update controls
//   IorD, MRead, MWrite, IRWrite    memory / IR controls
//   MtoR, RegDs, Urw                register-file write controls
//   ALUsrcA, ALUsrc, AOp            ALU operand / operation select
//   instr_done     pulse on the last cycle of each instruction
//   illegal        high while trapped on an unsupported opcode
module mc_cunit
  import mc_cunit_pkg::*;
#(
  parameter int unsigned AOP_W         = 3,
  parameter bit          ILLEGAL_TRAP  = 1'b1,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  UIn,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             IorD,
  output logic             MRead,
  output logic             MWrite,
  output logic             IRWrite,
  output logic             MtoR,
  output logic             RegDs,
  output logic             Urw,
  output logic             ALUsrcA,
  output logic [ALUB_W-1:0] ALUsrc,
  output logic [AOP_W-1:0] AOp,
  output logic             instr_done,
  output logic             illegal
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic            mem_rdy;
  ctrl_t           ctrl_c;

  // With the handshake disabled every memory access completes in one cycle.
  always_comb begin
    mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  end

  // State and captured-opcode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_RTYPE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Opcode is latched in decode so later UIn changes cannot disturb execute.
  always_comb begin
    opcode_d = opcode_q;
    if (state_q == S_DECODE) begin
      opcode_d = UIn;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (UIn)
          OP_RTYPE:                         state_d = S_REX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
          OP_LW, OP_SW:                     state_d = S_MADR;
          OP_BEQ:                           state_d = S_BEQ;
          OP_J:                             state_d = S_JMP;
          default: state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_MADR:   state_d = (opcode_q == OP_SW) ? S_MWR : S_MRD;
      S_MRD:    if (mem_rdy) state_d = S_MWB;
      S_MWR:    if (mem_rdy) state_d = S_FETCH;
      S_MWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  mc_cunit_odec #(
    .ILLEGAL_TRAP (ILLEGAL_TRAP)
  ) u_odec (
    .state   (state_q),
    .uin     (UIn),
    .opcode  (opcode_q),
    .mem_rdy (mem_rdy),
    .ctrl_c  (ctrl_c)
  );

  // Fan the strobe bundle out to the legacy port names.
  always_comb begin
    PCWrite    = ctrl_c.pc_write;
    Branch     = ctrl_c.branch;
    Jump       = ctrl_c.jump;
    IorD       = ctrl_c.iord;
    MRead      = ctrl_c.mread;
    MWrite     = ctrl_c.mwrite;
    IRWrite    = ctrl_c.ir_write;
    MtoR       = ctrl_c.mtor;
    RegDs      = ctrl_c.regds;
    Urw        = ctrl_c.urw;
    ALUsrcA    = ctrl_c.alusrc_a;
    ALUsrc     = ctrl_c.alusrc;
    AOp        = AOP_W'(ctrl_c.aop);
    instr_done = ctrl_c.instr_done;
    illegal    = ctrl_c.illegal;
  end

endmodule

// File: tb/tb_mc_cunit.sv
// tb_mc_cunit: directed scoreboard bench for mc_cunit. Each stimulus cycle
// queues the hand-derived control vector; a negedge monitor pops and compares.
// Vector layout: {PCWrite,Branch,Jump,IorD}_{MRead,MWrite,IRWrite,MtoR}_
//                {RegDs,Urw,ALUsrcA}_{ALUsrc}_{AOp}_{instr_done,illegal}
module tb_mc_cunit;

  localparam logic [17:0] E_IDLE    = 18'b0000_0000_000_00_000_00;
  localparam logic [17:0] E_FETCH   = 18'b1000_1010_000_01_011_00;
  localparam logic [17:0] E_FETCH_W = 18'b0000_1000_000_01_011_00;
  localparam logic [17:0] E_DECODE  = 18'b0000_0000_000_11_011_00;
  localparam logic [17:0] E_DEC_NOP = 18'b0000_0000_000_11_011_10;
  localparam logic [17:0] E_REX     = 18'b0000_0000_001_00_010_00;
  localparam logic [17:0] E_RWB     = 18'b0000_0000_110_00_000_10;
  localparam logic [17:0] E_IEX_ORI = 18'b0000_0000_001_10_110_00;
  localparam logic [17:0] E_IWB     = 18'b0000_0000_010_00_000_10;
  localparam logic [17:0] E_MADR    = 18'b0000_0000_001_10_011_00;
  localparam logic [17:0] E_MRD     = 18'b0001_1000_000_00_000_00;
  localparam logic [17:0] E_MWR_W   = 18'b0001_0100_000_00_000_00;
  localparam logic [17:0] E_MWR     = 18'b0001_0100_000_00_000_10;
  localparam logic [17:0] E_MWB     = 18'b0000_0001_010_00_000_10;
  localparam logic [17:0] E_BEQ     = 18'b0100_0000_001_00_001_10;
  localparam logic [17:0] E_JMP     = 18'b1010_0000_000_00_000_10;
  localparam logic [17:0] E_TRAP    = 18'b0000_0000_000_00_000_01;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, ORI = 6'b001101;
  localparam logic [5:0] BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] UIn = 6'd0;
  logic       mem_ready = 1'b1;

  logic       pcw1, br1, jmp1, iord1, mrd1, mwr1, irw1, mtor1, rds1, urw1, asa1, done1, ill1;
  logic [1:0] asb1;
  logic [2:0] aop1;
  logic       pcw2, br2, jmp2, iord2, mrd2, mwr2, irw2, mtor2, rds2, urw2, asa2, done2, ill2;
  logic [1:0] asb2;
  logic [2:0] aop2;
  logic [17:0] vec1, vec2;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic        sel_q[$];
  string       name_q[$];

  logic [17:0] m_exp, m_act;
  logic        m_sel;
  string       m_name;

  always #5 clk = ~clk;

  mc_cunit #(.AOP_W(3), .ILLEGAL_TRAP(1'b1), .MEM_HANDSHAKE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .UIn(UIn), .mem_ready(mem_ready),
    .PCWrite(pcw1), .Branch(br1), .Jump(jmp1), .IorD(iord1), .MRead(mrd1),
    .MWrite(mwr1), .IRWrite(irw1), .MtoR(mtor1), .RegDs(rds1), .Urw(urw1),
    .ALUsrcA(asa1), .ALUsrc(asb1), .AOp(aop1), .instr_done(done1), .illegal(ill1)
  );

  mc_cunit #(.AOP_W(3), .ILLEGAL_TRAP(1'b0), .MEM_HANDSHAKE(1'b1)) u_nop (
    .clk(clk), .rst(rst), .UIn(UIn), .mem_ready(mem_ready),
    .PCWrite(pcw2), .Branch(br2), .Jump(jmp2), .IorD(iord2), .MRead(mrd2),
    .MWrite(mwr2), .IRWrite(irw2), .MtoR(mtor2), .RegDs(rds2), .Urw(urw2),
    .ALUsrcA(asa2), .ALUsrc(asb2), .AOp(aop2), .instr_done(done2), .illegal(ill2)
  );

  assign vec1 = {pcw1, br1, jmp1, iord1, mrd1, mwr1, irw1, mtor1,
                 rds1, urw1, asa1, asb1, aop1, done1, ill1};
  assign vec2 = {pcw2, br2, jmp2, iord2, mrd2, mwr2, irw2, mtor2,
                 rds2, urw2, asa2, asb2, aop2, done2, ill2};

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input logic r, input logic [5:0] u, input logic m,
                      input logic s, input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r;
    UIn = u;
    mem_ready = m;
    exp_q.push_back(e);
    sel_q.push_back(s);
    name_q.push_back(nm);
  endtask

  // Monitor: pop and compare whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp  = exp_q.pop_front();
      m_sel  = sel_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = m_sel ? vec2 : vec1;
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", m_name, m_act, m_exp);
      end
      checks++;
      if ((mrd1 && mwr1) || (pcw1 && br1)) begin
        errors++;
        $display("FAIL excl_%s: MRead=%b MWrite=%b PCWrite=%b Branch=%b expected no overlap",
                 m_name, mrd1, mwr1, pcw1, br1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  logic [5:0]  iop  [3];
  logic [17:0] iexp [3];

  initial begin
    iop[0] = 6'b001000; iexp[0] = 18'b0000_0000_001_10_011_00;
    iop[1] = 6'b001010; iexp[1] = 18'b0000_0000_001_10_100_00;
    iop[2] = 6'b001100; iexp[2] = 18'b0000_0000_001_10_101_00;

    // Reset and R-type
    step(1, RT, 1, 0, E_IDLE,   "reset");
    step(0, RT, 1, 0, E_IDLE,   "r_idle");
    step(0, RT, 1, 0, E_FETCH,  "r_fetch");
    step(0, RT, 1, 0, E_DECODE, "r_decode");
    step(0, RT, 1, 0, E_REX,    "r_rex");
    step(0, RT, 1, 0, E_RWB,    "r_rwb");

    // LW with two wait cycles in the read
    step(0, LW, 1, 0, E_FETCH,  "lw_fetch");
    step(0, LW, 1, 0, E_DECODE, "lw_decode");
    step(0, LW, 1, 0, E_MADR,   "lw_madr");
    step(0, LW, 0, 0, E_MRD,    "lw_mrd_w1");
    step(0, LW, 0, 0, E_MRD,    "lw_mrd_w2");
    step(0, LW, 1, 0, E_MRD,    "lw_mrd");
    step(0, LW, 1, 0, E_MWB,    "lw_mwb");

    // SW then BEQ
    step(0, SW, 1, 0, E_FETCH,  "sw_fetch");
    step(0, SW, 1, 0, E_DECODE, "sw_decode");
    step(0, SW, 1, 0, E_MADR,   "sw_madr");
    step(0, SW, 1, 0, E_MWR,    "sw_mwr");
    step(0, BQ, 1, 0, E_FETCH,  "beq_fetch");
    step(0, BQ, 1, 0, E_DECODE, "beq_decode");
    step(0, BQ, 1, 0, E_BEQ,    "beq_exec");

    // SW with stalls in fetch and in the write
    step(0, SW, 0, 0, E_FETCH_W, "sw2_fetch_w");
    step(0, SW, 1, 0, E_FETCH,   "sw2_fetch");
    step(0, SW, 1, 0, E_DECODE,  "sw2_decode");
    step(0, SW, 1, 0, E_MADR,    "sw2_madr");
    step(0, SW, 0, 0, E_MWR_W,   "sw2_mwr_w");
    step(0, SW, 1, 0, E_MWR,     "sw2_mwr");

    // ORI with UIn changed after decode
    step(0, ORI, 1, 0, E_FETCH,   "ori_fetch");
    step(0, ORI, 1, 0, E_DECODE,  "ori_decode");
    step(0, RT,  1, 0, E_IEX_ORI, "ori_iex");
    step(0, RT,  1, 0, E_IWB,     "ori_iwb");

    // Remaining immediate ALU ops
    for (int i = 0; i < 3; i++) begin
      step(0, iop[i], 1, 0, E_FETCH,  "imm_fetch");
      step(0, iop[i], 1, 0, E_DECODE, "imm_decode");
      step(0, iop[i], 1, 0, iexp[i],  "imm_iex");
      step(0, iop[i], 1, 0, E_IWB,    "imm_iwb");
    end

    // Reset during a fetch stall, then J
    step(0, JJ, 0, 0, E_FETCH_W, "j_fetch_w");
    step(1, JJ, 0, 0, E_FETCH_W, "j_rst_stall");
    step(0, JJ, 1, 0, E_IDLE,    "j_rst_idle");
    step(0, JJ, 1, 0, E_FETCH,   "j_fetch");
    step(0, JJ, 1, 0, E_DECODE,  "j_decode");
    step(0, JJ, 1, 0, E_JMP,     "j_exec");

    // Unsupported opcode traps until reset
    step(0, BAD, 1, 0, E_FETCH,  "bad_fetch");
    step(0, BAD, 1, 0, E_DECODE, "bad_decode");
    for (int i = 0; i < 20; i++) begin
      step(0, BAD, logic'(i % 2), 0, E_TRAP, "trap_hold");
    end
    step(1, RT, 1, 0, E_TRAP, "trap_rst");
    step(0, RT, 1, 0, E_IDLE, "trap_idle");

    // Same opcode on the skip-as-NOP instance
    step(0, BAD, 1, 1, E_FETCH,   "nop_fetch");
    step(0, BAD, 1, 1, E_DEC_NOP, "nop_decode");
    step(0, RT,  1, 1, E_FETCH,   "nop_refetch");
    step(0, RT,  1, 1, E_DECODE,  "nop_decode2");
    step(0, RT,  1, 1, E_REX,     "nop_rex");
    step(0, RT,  1, 0, E_TRAP,    "trap_again");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cunit.md
Name: mc_cunit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder. The MIPS datapath is shared across cycles, so this block is a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the existing control names (RegDs, Branch, MRead, MtoR, AOp, MWrite, ALUsrc, Urw, Jump) plus the multi-cycle strobes.
- Stalls on a memory-ready handshake.
- Handles unsupported opcodes, either by trapping or by skipping them.

Parameters:
- AOP_W, 3: AOp width. Must be ≥3; upper bits are zero-extended.
- ILLEGAL_TRAP, 1: 1 = an unsupported opcode enters S_TRAP until reset; 0 = it is treated as a NOP and the FSM returns to S_FETCH.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- UIn  in  6  opcode, instr[31:26]. Sampled only in S_DECODE (from IR, already stable).
- mem_ready  in  1  memory completed the access this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load; PC loads if ALU zero
- Jump  out  1  PC source = jump target
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MRead  out  1
- MWrite  out  1
- IRWrite  out  1
- MtoR  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegDs  out  1  register destination: 1 = rd, 0 = rt
- Urw  out  1  register file write
- ALUsrcA  out  1  ALU A input: 0 = PC, 1 = rs
- ALUsrc  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- AOp  out  AOP_W  ALU op: 001 sub, 010 R-type funct, 011 add, 100 slt, 101 and, 110 or
- instr_done  out  1  1-cycle pulse on the last cycle of each instruction
- illegal  out  1  high while in S_TRAP

Behaviour:
- All outputs are Moore-decoded from the state register only, with no X values; every output not listed for a state is 0.
- Reset: rst high at a clock edge sets state = S_IDLE, and all outputs are 0 in S_IDLE. rst takes priority over every transition, including mid-memory-wait and S_TRAP.
- S_IDLE -> S_FETCH unconditionally.
- S_FETCH:
  - Outputs: MRead=1, IorD=0, ALUsrcA=0, ALUsrc=01, AOp=011.
  - IRWrite=1 and PCWrite=1 are asserted only while mem_ready=1. This is the single allowed Mealy exception: a mem_ready gate on the strobes.
  - Stays in S_FETCH while mem_ready=0; otherwise -> S_DECODE.
- S_DECODE:
  - Outputs: ALUsrcA=0, ALUsrc=11, AOp=011.
  - Next state by UIn:
    - 000000 -> S_REX
    - 001000/001010/001100/001101 -> S_IEX
    - 100011/101011 -> S_MADR
    - 000100 -> S_BEQ
    - 000010 -> S_JMP
    - any other opcode -> S_TRAP if ILLEGAL_TRAP, else S_FETCH with instr_done=1
- S_REX: ALUsrcA=1, ALUsrc=00, AOp=010 -> S_RWB.
- S_RWB: RegDs=1, MtoR=0, Urw=1, instr_done=1 -> S_FETCH.
- S_IEX: ALUsrcA=1, ALUsrc=10. AOp by opcode: ADDI 011, SLTI 100, ANDI 101, ORI 110. The opcode is captured in an internal 6-bit register in S_DECODE, so a UIn change after decode has no effect -> S_IWB.
- S_IWB: RegDs=0, MtoR=0, Urw=1, instr_done=1 -> S_FETCH.
- S_MADR: ALUsrcA=1, ALUsrc=10, AOp=011 -> S_MRD (LW) or S_MWR (SW).
- S_MRD: MRead=1, IorD=1. Waits while mem_ready=0 -> S_MWB.
- S_MWR: MWrite=1, IorD=1. Waits while mem_ready=0. On mem_ready: instr_done=1 -> S_FETCH.
- S_MWB: RegDs=0, MtoR=1, Urw=1, instr_done=1 -> S_FETCH.
- S_BEQ: ALUsrcA=1, ALUsrc=00, AOp=001, Branch=1, instr_done=1 -> S_FETCH.
- S_JMP: Jump=1, PCWrite=1, instr_done=1 -> S_FETCH.
- S_TRAP: illegal=1; all strobes 0. Stays until rst.
- Latency with mem_ready tied 1, counted in cycles:

  | Instruction | Cycles |
  |---|---|
  | BEQ | 3 |
  | J | 3 |
  | R-type | 4 |
  | I-type ALU | 4 |
  | SW | 4 |
  | LW | 5 |
  | Illegal NOP | 2 |

  Each cycle with mem_ready=0 in a memory state adds exactly 1.
- Simultaneous: MRead and MWrite are never both 1. PCWrite and Branch are never both 1.

Decomposition:
- Shared package mc_cunit_pkg:
  - state enum, 4-bit encoding
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J
  - AOp constants: AOP_SUB, AOP_FUNCT, AOP_ADD, AOP_SLT, AOP_AND, AOP_OR
  - ALU B-select constants
- Sub-module: mc_cunit_odec, a combinational state+opcode -> output decoder. The top level keeps the state register, the opcode capture register and the next-state logic.

Test Plan:
- Reset, then R-type (UIn=000000, mem_ready=1) -> states IDLE,FETCH,DECODE,REX,RWB. Urw=RegDs=1 only in RWB; instr_done pulses at cycle 5 after reset.
- LW (100011) with mem_ready low for 2 cycles in S_MRD -> MRead=IorD=1 held 3 cycles; MtoR=Urw=1 in the next cycle; total 7 cycles FETCH..MWB.
- SW (101011) then BEQ (000100) -> MWrite=1 exactly 1 cycle with mem_ready=1; Branch=1, AOp=001 in the third cycle of BEQ; MRead&MWrite never both 1.
- ORI (001101) with UIn changed to 000000 during S_IEX -> AOp=110 held; RegDs=0 in IWB.
- Opcode 111111 with ILLEGAL_TRAP=1 -> illegal=1 from cycle 3, persists 20 cycles; rst=1 -> S_IDLE, illegal=0. With ILLEGAL_TRAP=0 -> instr_done in DECODE, back to FETCH.
- rst asserted during a S_FETCH stall (mem_ready=0) -> next cycle all outputs 0, S_IDLE; J (000010) afterwards -> Jump=PCWrite=1 in cycle 3.
